fade_sequencer: RTL and testbench
=================================

# fade_sequencer

Upstream controller for the fade-out stage. Steps the 3-bit fade-period select through 1..7 on a fixed dwell timer and issues a one-cycle restart pulse to the fade-out stage at every period change. Accepts a raw push-button input for manual skip and, optionally, pause. Runs on the 100 kHz LED-show clock; `io_fadeRestart` is OR'ed into the fade-out stage's `reset`.

## Interface
- `DWELL_TICKS`, default 50000: clock cycles per segment (0.5 s at 100 kHz).
- `DEBOUNCE_TICKS`, default 1000: consecutive stable cycles before the button level is accepted.
- `LONG_TICKS`, default 100000: debounced hold length that counts as a long press (pause build only).
- `clock`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high.
- `io_button`, input, 1: raw, asynchronous button level, active-high.
- `io_realPeriod`, output, 3: period select to the fade-out stage; always 1..7.
- `io_fadeRestart`, output, 1: single-cycle restart pulse to the fade-out stage.
- `io_paused`, output, 1: high while the sequence is frozen.

## Operation
- States: RESTART, DWELL, PAUSE.
- Reset values:
  - state RESTART, `io_realPeriod` = 1, `io_fadeRestart` = 0, `io_paused` = 0.
  - Dwell counter 0; debouncer and synchroniser cleared to 0.
- RESTART (lasts exactly 1 cycle):
  - `io_fadeRestart` = 1.
  - Next state DWELL, or PAUSE if the pause flag is set.
  - Dwell counter cleared.
- DWELL:
  - Counter increments each cycle.
  - At count `DWELL_TICKS`-1 the block advances: period+1 with 7 wrapping to 1, then RESTART.
- Skip event in DWELL: advance immediately and go to RESTART. Skip coinciding with terminal count gives a single advance.
- Events arriving during RESTART are dropped.
- Period value 0 is never driven.
- Button path:
  - 2-flop synchroniser.
  - Debounce counter resets on any change of the synchronised level.
  - The debounced level updates after `DEBOUNCE_TICKS` stable cycles.
- Arithmetic:
  - Counters are sized with `$clog2` of their parameter.
  - The long-press counter saturates at `LONG_TICKS` and never wraps.

## Timing
- First `io_fadeRestart` occurs in the first cycle after `reset` deasserts, with `io_realPeriod` = 1.
- `io_realPeriod` changes in the same cycle that `io_fadeRestart` rises and stays stable until the next restart.
- Restart pulses are spaced `DWELL_TICKS`+1 cycles apart in free-run.
- Button-to-event latency is 2 (sync) + `DEBOUNCE_TICKS` cycles after the relevant edge. The skip takes effect on the cycle after the event.
- Reset mid-operation returns all outputs to their reset values on the next edge. No pulse is emitted during reset.

## Configuration
- `FADE_SEQ_PAUSE_EN` defined:
  - Short press = debounced release with hold < `LONG_TICKS`; generates a skip.
  - Long press = hold reaching `LONG_TICKS`. It fires once per press, toggles the pause flag, and its release generates nothing.
  - Entering pause: DWELL goes to PAUSE, dwell counter frozen, `io_paused` = 1.
  - Leaving pause: PAUSE goes to DWELL, counter resumes from its frozen value.
  - Skip in PAUSE: advance, RESTART, then back to PAUSE.
- `FADE_SEQ_PAUSE_EN` undefined:
  - The debounced rising edge generates a skip and there is no hold timing.
  - PAUSE is unreachable, `io_paused` is tied 0, and `LONG_TICKS` is unused.

## Structure
- Package `fade_pkg`:
  - `PERIOD_W` = 3, `PERIOD_MIN` = 1, `PERIOD_MAX` = 7.
  - State enum {RESTART, DWELL, PAUSE}.
- Sub-module `step_debouncer`:
  - Contains the synchroniser, debounce counter and press classification.
  - Outputs single-cycle `skip` and `toggle` pulses.
- The top level holds the FSM, the dwell counter and the period register.

## Test plan
Test parameters: `DWELL_TICKS`=20, `DEBOUNCE_TICKS`=4, `LONG_TICKS`=50.
- Free-run from reset, button low: pulses at cycles 0, 21, 42, …; `io_realPeriod` runs 1,2,…,7,1. It reaches 1 again at pulse 8, and is never 0.
- Clean press of 10 cycles at DWELL count 5:
  - Without the macro, restart with period+1 at 7 cycles after the rising edge.
  - With the macro, the same occurs 7 cycles after release.
- Glitch: 3-cycle high pulse, then 2-cycle pulse → no skip, period unchanged.
- Skip asserted on the terminal-count cycle → exactly one advance, single restart pulse.
- Pause build, 60-cycle hold at count 8:
  - `io_paused` rises, counter frozen at its current value.
  - A 10-cycle press gives period+1 with a restart, remaining paused.
  - A second 60-cycle hold resumes; the next restart follows after the remaining dwell.
- `reset` asserted mid-DWELL at period 5 → next cycle `io_realPeriod` = 1, `io_paused` = 0. The first restart pulse comes on the first cycle after release.

Source files
------------

// File: rtl/fade_pkg.sv
// Shared types and constants for the fade-period sequencer.
package fade_pkg;

    localparam int PERIOD_W = 3;
    localparam logic [PERIOD_W-1:0] PERIOD_MIN = 3'd1;
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = 3'd7;

    typedef enum logic [1:0] {
        RESTART,
        DWELL,
        PAUSE
    } state_t;

    // 7 wraps to 1 so that period 0 can never be produced
    function automatic logic [PERIOD_W-1:0] next_period(
        input logic [PERIOD_W-1:0] p
    );
        return (p >= PERIOD_MAX) ? PERIOD_MIN : p + 1'b1;
    endfunction

endpackage

// File: rtl/fade_sequencer_step_debouncer.sv
// Button synchroniser, debouncer and press classifier.
// FADE_SEQ_PAUSE_EN selects release-based skip plus long-press toggle.
module step_debouncer #(
    parameter int DEBOUNCE_TICKS = 1000,
    parameter int LONG_TICKS     = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic skip,
    output logic toggle
);

    localparam int DBW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_TICKS - 1);

    logic           sync1;
    logic           sync2;
    logic           level;
    logic [DBW-1:0] db_cnt;
    logic           settle;

    assign settle = (sync2 != level) && (db_cnt == DB_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (settle) begin
                db_cnt <= '0;
                level  <= sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef FADE_SEQ_PAUSE_EN
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

    logic [HW-1:0] hold;

    // A hold that reached HOLD_MAX already toggled, so its release is silent
    always_ff @(posedge clock) begin
        if (reset) begin
            hold   <= '0;
            skip   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            if (!level)
                hold <= '0;
            else if (hold != HOLD_MAX)
                hold <= hold + 1'b1;
            toggle <= level && !settle && (hold == HOLD_MAX - 1'b1);
            skip   <= level && settle && (hold != HOLD_MAX);
        end
    end
`else
    logic long_unused;

    assign long_unused = (LONG_TICKS > 0);
    assign toggle      = 1'b0;

    always_ff @(posedge clock) begin
        if (reset)
            skip <= 1'b0;
        else
            skip <= settle && !level;
    end
`endif

endmodule

// File: rtl/fade_sequencer.sv
// Steps the fade period 1..7 on a dwell timer with restart pulses.
// FADE_SEQ_PAUSE_EN adds long-press pause/resume.
module fade_sequencer
    import fade_pkg::*;
#(
    parameter int DWELL_TICKS    = 50000,
    parameter int DEBOUNCE_TICKS = 1000,
    parameter int LONG_TICKS     = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_button,
    output logic [PERIOD_W-1:0] io_realPeriod,
    output logic                io_fadeRestart,
    output logic                io_paused
);

    localparam int CW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_TICKS - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [PERIOD_W-1:0] period;
    logic                restart;
    logic                pause_flag;
    logic                skip;
    logic                toggle;

    step_debouncer #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .LONG_TICKS    (LONG_TICKS)
    ) u_deb (
        .clock (clock),
        .reset (reset),
        .button(io_button),
        .skip  (skip),
        .toggle(toggle)
    );

`ifndef FADE_SEQ_PAUSE_EN
    assign pause_flag = 1'b0;
`endif

    // RESTART with restart low only happens right after reset: arm the pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RESTART;
            cnt     <= '0;
            period  <= PERIOD_MIN;
            restart <= 1'b0;
`ifdef FADE_SEQ_PAUSE_EN
            pause_flag <= 1'b0;
`endif
        end else begin
`ifdef FADE_SEQ_PAUSE_EN
            if (toggle && state != RESTART)
                pause_flag <= !pause_flag;
`endif
            unique case (state)
                RESTART: begin
                    cnt <= '0;
                    if (!restart) begin
                        restart <= 1'b1;
                    end else begin
                        restart <= 1'b0;
                        state   <= pause_flag ? PAUSE : DWELL;
                    end
                end
                DWELL: begin
                    if (skip || cnt == CNT_LAST) begin
                        period  <= next_period(period);
                        restart <= 1'b1;
                        state   <= RESTART;
                    end else if (toggle) begin
                        state <= PAUSE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    if (skip) begin
                        period  <= next_period(period);
                        restart <= 1'b1;
                        state   <= RESTART;
                    end else if (toggle) begin
                        state <= DWELL;
                    end
                end
                default: state <= RESTART;
            endcase
        end
    end

    assign io_realPeriod  = period;
    assign io_fadeRestart = restart;
    assign io_paused      = pause_flag;

endmodule

// File: tb/tb_fade_sequencer.sv
// Directed bench for fade_sequencer (DWELL 20, DEBOUNCE 4, LONG 50).
module tb_fade_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_button = 1'b0;
    logic [2:0] io_realPeriod;
    logic       io_fadeRestart;
    logic       io_paused;

    int checks = 0;
    int errors = 0;
    int since  = 0;
    int n;
    bit st;

    always #5 clock = ~clock;

    fade_sequencer #(
        .DWELL_TICKS   (20),
        .DEBOUNCE_TICKS(4),
        .LONG_TICKS    (50)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_button     (io_button),
        .io_realPeriod (io_realPeriod),
        .io_fadeRestart(io_fadeRestart),
        .io_paused     (io_paused)
    );

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clock);
            if (io_fadeRestart === 1'b1) since = 0;
            else since++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // got = maxn+1 when no pulse arrives within maxn cycles
    task automatic wait_pulse(input int maxn, output int got,
                              output bit stab);
        logic [2:0] p0;
        p0   = io_realPeriod;
        got  = maxn + 1;
        stab = 1'b1;
        for (int i = 1; i <= maxn; i++) begin
            tick(1);
            if (io_fadeRestart === 1'b1) begin
                got = i;
                break;
            end
            if (io_realPeriod !== p0) stab = 1'b0;
        end
    endtask

    task automatic gap(input int exp_n, input int exp_p, input string tag);
        int  got;
        bit  stab;
        wait_pulse(30, got, stab);
        chk({tag, "_gap"}, got, exp_n);
        chk({tag, "_period"}, io_realPeriod, exp_p);
        chk({tag, "_stable"}, stab, 1);
    endtask

    task automatic long_hold(input bit to);
        io_button = 1'b1;
        tick(56);
        chk("hold_before", io_paused, !to);
        tick(1);
        chk("hold_after", io_paused, to);
        tick(3);
        io_button = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_restart", io_fadeRestart, 0);
        chk("rst_period", io_realPeriod, 1);
        chk("rst_paused", io_paused, 0);

        reset = 1'b0;
        tick(1);
        chk("first_pulse", io_fadeRestart, 1);
        chk("first_period", io_realPeriod, 1);
        for (int p = 1; p <= 7; p++) gap(21, (p % 7) + 1, "free");

`ifdef FADE_SEQ_PAUSE_EN
        tick(2);
        io_button = 1'b1;
        tick(10);
        io_button = 1'b0;
        gap(7, 2, "press");
`else
        tick(6);
        io_button = 1'b1;
        gap(7, 2, "press");
        tick(3);
        io_button = 1'b0;
`endif
        gap(21 - since, 3, "post_press");

        io_button = 1'b1;
        tick(3);
        io_button = 1'b0;
        tick(3);
        io_button = 1'b1;
        tick(2);
        io_button = 1'b0;
        gap(21 - since, 4, "glitch");

`ifdef FADE_SEQ_PAUSE_EN
        tick(4);
        io_button = 1'b1;
        tick(10);
        io_button = 1'b0;
        gap(21 - since, 5, "tc_skip");
`else
        tick(14);
        io_button = 1'b1;
        gap(21 - since, 5, "tc_skip");
        tick(3);
        io_button = 1'b0;
`endif
        gap(21 - since, 6, "tc_next");

`ifdef FADE_SEQ_PAUSE_EN
        long_hold(1'b1);
        chk("pause_period", io_realPeriod, 1);
        wait_pulse(25, n, st);
        chk("pause_quiet", n, 26);
        long_hold(1'b0);
        gap(4, 2, "resume");
        long_hold(1'b1);
        chk("pause2_period", io_realPeriod, 4);
        tick(8);
        io_button = 1'b1;
        tick(10);
        io_button = 1'b0;
        gap(7, 5, "pause_skip");
        chk("skip_paused", io_paused, 1);
        wait_pulse(25, n, st);
        chk("skip_quiet", n, 26);
`endif

        tick(8);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_period", io_realPeriod, 1);
        chk("mid_rst_paused", io_paused, 0);
        chk("mid_rst_restart", io_fadeRestart, 0);
        tick(2);
        chk("rst_hold_restart", io_fadeRestart, 0);
        reset = 1'b0;
        tick(1);
        chk("rel_pulse", io_fadeRestart, 1);
        chk("rel_period", io_realPeriod, 1);
        gap(21, 2, "rel");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
